// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - next-PC sequencer with exception PC and optional return-address stack
// Define PC_SEQ_RAS_EN to build the return-address stack; without it CALL acts as JUMP and RETURN as REG.
module pc_sequencer #(
    parameter int              PC_W      = 30,
    parameter logic [PC_W-1:0] RESET_VEC = '0,
    parameter logic [PC_W-1:0] EXC_VEC   = 30'h0000_0020,
    parameter int              RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic [2:0]      pc_source,
    input  logic            take_branch,
    input  logic [25:0]     opcode25_0,
    input  logic [PC_W-1:0] pc_new,
    input  logic            exc_req,
    input  logic            eret,
    output logic [PC_W-1:0] pc_current,
    output logic [PC_W-1:0] pc_plus1,
    output logic [PC_W-1:0] epc,
    output logic            ras_empty,
    output logic            ras_full
);

    localparam logic [2:0] SRC_JUMP   = 3'd1;
    localparam logic [2:0] SRC_BRANCH = 3'd2;
    localparam logic [2:0] SRC_REG    = 3'd3;
    localparam logic [2:0] SRC_CALL   = 3'd4;
    localparam logic [2:0] SRC_RETURN = 3'd5;

    if (PC_W < 27 || PC_W > 30 || RAS_DEPTH < 2 || RAS_DEPTH > 16 ||
        (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_params
        $error("pc_sequencer: illegal PC_W or RAS_DEPTH");
    end

    logic [PC_W-1:0] pc_d;
    logic [PC_W-1:0] epc_d;
    logic [PC_W-1:0] jump_tgt;
    logic [PC_W-1:0] branch_tgt;

    assign pc_plus1   = pc_current + {{(PC_W-1){1'b0}}, 1'b1};
    assign jump_tgt   = {pc_current[PC_W-1:26], opcode25_0};
    assign branch_tgt = pc_current + {{(PC_W-16){opcode25_0[15]}}, opcode25_0[15:0]};

`ifdef PC_SEQ_RAS_EN
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RAS_DEPTH);

    // ras_ptr is the next free slot; once full, pushes wrap over the oldest entry.
    logic [PC_W-1:0]  ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] ras_ptr;
    logic [CNT_W-1:0] ras_count;
    logic [PTR_W-1:0] ras_top_idx;
    logic             push;
    logic             pop;

    assign ras_top_idx = ras_ptr - {{(PTR_W-1){1'b0}}, 1'b1};
    assign ras_empty   = (ras_count == '0);
    assign ras_full    = (ras_count == DEPTH_C);
`else
    assign ras_empty = 1'b1;
    assign ras_full  = 1'b0;
`endif

    always_comb begin
        pc_d  = pc_current;
        epc_d = epc;
`ifdef PC_SEQ_RAS_EN
        push  = 1'b0;
        pop   = 1'b0;
`endif
        if (exc_req) begin
            pc_d  = EXC_VEC;
            epc_d = pc_current;
        end else if (eret) begin
            pc_d = epc;
        end else if (!stall) begin
            case (pc_source)
                SRC_JUMP:   pc_d = jump_tgt;
                SRC_BRANCH: pc_d = take_branch ? branch_tgt : pc_plus1;
                SRC_REG:    pc_d = pc_new;
                SRC_CALL: begin
                    pc_d = jump_tgt;
`ifdef PC_SEQ_RAS_EN
                    push = 1'b1;
`endif
                end
                SRC_RETURN: begin
                    pc_d = pc_new;
`ifdef PC_SEQ_RAS_EN
                    if (!ras_empty) begin
                        pc_d = ras_mem[ras_top_idx];
                        pop  = 1'b1;
                    end
`endif
                end
                default:    pc_d = pc_plus1;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_current <= RESET_VEC;
            epc        <= '0;
`ifdef PC_SEQ_RAS_EN
            ras_ptr    <= '0;
            ras_count  <= '0;
`endif
        end else begin
            pc_current <= pc_d;
            epc        <= epc_d;
`ifdef PC_SEQ_RAS_EN
            if (push) begin
                ras_ptr <= ras_ptr + {{(PTR_W-1){1'b0}}, 1'b1};
                if (!ras_full) ras_count <= ras_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end else if (pop) begin
                ras_ptr   <= ras_top_idx;
                ras_count <= ras_count - {{(CNT_W-1){1'b0}}, 1'b1};
            end
`endif
        end
    end

`ifdef PC_SEQ_RAS_EN
    // Stack contents need no reset; validity is tracked by ras_count alone.
    always_ff @(posedge clk) begin
        if (push) ras_mem[ras_ptr] <= pc_plus1;
    end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - randomized self-checking bench for pc_sequencer against a queue-based model
module tb_pc_sequencer;

    localparam int    PC_W  = 30;
    localparam int    DEPTH = 4;
    localparam longint MASK = (64'd1 << PC_W) - 1;
    localparam longint EXC  = 64'h20;
`ifdef PC_SEQ_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            stall;
    logic [2:0]      pc_source;
    logic            take_branch;
    logic [25:0]     opcode25_0;
    logic [PC_W-1:0] pc_new;
    logic            exc_req;
    logic            eret;
    logic [PC_W-1:0] pc_current;
    logic [PC_W-1:0] pc_plus1;
    logic [PC_W-1:0] epc;
    logic            ras_empty;
    logic            ras_full;

    int n_checks = 0;
    int n_errors = 0;

    longint m_pc;
    longint m_epc;
    longint m_ras[$];

    pc_sequencer dut (
        .clk(clk), .rst(rst), .stall(stall), .pc_source(pc_source),
        .take_branch(take_branch), .opcode25_0(opcode25_0), .pc_new(pc_new),
        .exc_req(exc_req), .eret(eret), .pc_current(pc_current), .pc_plus1(pc_plus1),
        .epc(epc), .ras_empty(ras_empty), .ras_full(ras_full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"}, 64'(pc_current), m_pc);
        check({tag, ".epc"}, 64'(epc), m_epc);
        check({tag, ".plus1"}, 64'(pc_plus1), (m_pc + 1) & MASK);
        check({tag, ".empty"}, 64'(ras_empty), RAS_ON ? 64'(m_ras.size() == 0) : 64'd1);
        check({tag, ".full"}, 64'(ras_full), RAS_ON ? 64'(m_ras.size() == DEPTH) : 64'd0);
    endtask

    function automatic void model_reset();
        m_pc  = 0;
        m_epc = 0;
        m_ras.delete();
    endfunction

    // One clock: drive inputs, predict the next state from the rules, then compare after the edge.
    task automatic step(input logic [2:0] src, input logic br, input logic [25:0] op,
                        input logic [PC_W-1:0] pn, input logic ex, input logic er, input logic st);
        longint npc, nepc, jmp;
        pc_source = src; take_branch = br; opcode25_0 = op; pc_new = pn;
        exc_req = ex; eret = er; stall = st;
        npc  = m_pc;
        nepc = m_epc;
        jmp  = (m_pc & (MASK & ~64'h3FF_FFFF)) | longint'(op);
        if (ex) begin
            npc  = EXC;
            nepc = m_pc;
        end else if (er) begin
            npc = m_epc;
        end else if (!st) begin
            case (src)
                3'd1: npc = jmp;
                3'd2: npc = br ? ((m_pc + longint'($signed(op[15:0]))) & MASK) : ((m_pc + 1) & MASK);
                3'd3: npc = longint'(pn);
                3'd4: begin
                    npc = jmp;
                    if (RAS_ON) begin
                        m_ras.push_back((m_pc + 1) & MASK);
                        if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
                    end
                end
                3'd5: npc = (RAS_ON && m_ras.size() > 0) ? m_ras.pop_back() : longint'(pn);
                default: npc = (m_pc + 1) & MASK;
            endcase
        end
        @(posedge clk);
        #1;
        m_pc  = npc;
        m_epc = nepc;
        check_all("step");
    endtask

    task automatic set_pc(input logic [PC_W-1:0] v);
        step(3'd3, 1'b0, 26'd0, v, 1'b0, 1'b0, 1'b0);
    endtask

    // Reset pulse placed between clock edges; the PC must clear without waiting for an edge.
    task automatic mid_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("async_rst.pc", 64'(pc_current), 64'd0);
        check_all("async_rst");
        #1 rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; pc_source = 3'd0; take_branch = 1'b0;
        opcode25_0 = '0; pc_new = '0; exc_req = 1'b0; eret = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;

        for (int i = 1; i <= 3; i++) begin
            step(3'd0, 1'b0, 26'd0, '0, 1'b0, 1'b0, 1'b0);
            check("inc_seq", 64'(pc_current), 64'(i));
        end
        mid_reset();

        set_pc(30'h100);
        step(3'd2, 1'b1, 26'h000_FFF0, '0, 1'b0, 1'b0, 1'b0);
        check("branch_taken", 64'(pc_current), 64'h0F0);
        set_pc(30'h100);
        step(3'd2, 1'b0, 26'h000_FFF0, '0, 1'b0, 1'b0, 1'b0);
        check("branch_not_taken", 64'(pc_current), 64'h101);

        set_pc(30'h3FFF_FFFF);
        step(3'd0, 1'b0, 26'd0, '0, 1'b0, 1'b0, 1'b0);
        check("inc_wrap", 64'(pc_current), 64'h0);
        set_pc(30'h1000_0000);
        step(3'd1, 1'b0, 26'h000_0040, '0, 1'b0, 1'b0, 1'b0);
        check("jump", 64'(pc_current), 64'h1000_0040);

        set_pc(30'h200);
        step(3'd0, 1'b0, 26'd0, '0, 1'b1, 1'b0, 1'b1);
        check("exc_pc", 64'(pc_current), EXC);
        check("exc_epc", 64'(epc), 64'h200);
        step(3'd0, 1'b0, 26'd0, '0, 1'b0, 1'b1, 1'b0);
        check("eret_pc", 64'(pc_current), 64'h200);

        step(3'd4, 1'b0, 26'h123, '0, 1'b0, 1'b0, 1'b1);
        check("stall_call", 64'(pc_current), 64'h200);

`ifdef PC_SEQ_RAS_EN
        set_pc(30'h10);
        for (int i = 2; i <= 6; i++) step(3'd4, 1'b0, 26'(i * 16), '0, 1'b0, 1'b0, 1'b0);
        check("ras_full_after5", 64'(ras_full), 64'd1);
        for (int i = 5; i >= 2; i--) begin
            step(3'd5, 1'b0, 26'd0, 30'h99, 1'b0, 1'b0, 1'b0);
            check("ras_return", 64'(pc_current), 64'(i * 16 + 1));
        end
        step(3'd5, 1'b0, 26'd0, 30'h99, 1'b0, 1'b0, 1'b0);
        check("ras_return_empty", 64'(pc_current), 64'h99);
`endif

        mid_reset();
        step(3'd5, 1'b0, 26'd0, 30'h77, 1'b0, 1'b0, 1'b0);
        check("return_empty", 64'(pc_current), 64'h77);
        check("return_empty.flag", 64'(ras_empty), 64'd1);

        for (int i = 0; i < 400; i++) begin
            if (i == 200) mid_reset();
            step(3'($urandom_range(0, 7)), 1'($urandom), 26'($urandom), PC_W'($urandom),
                 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 15) == 0),
                 1'($urandom_range(0, 3) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
